wb_write_arbiter: RTL and testbench

Write-back arbiter and buffer that drives the register file's single write port (rdwr/addr3/data3). It accepts write-back requests from the ALU path and the load path over valid/ready handshakes and queues them in an in-order FIFO. It issues at most one register write per cycle and exposes pending-write hazard flags for the two read addresses so decode can stall on RAW conflicts.

---
 rtl/wb_write_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: queues ALU/load register writes in an in-order FIFO and
// drives the register file's single write port, flagging RAW hazards for decode.
module wb_write_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 4,
    parameter int DROP_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ready,
    input  logic                     wb_stall,
    output logic                     rdwr,
    output logic [ADDR_W-1:0]        addr3,
    output logic [DATA_W-1:0]        data3,
    input  logic [ADDR_W-1:0]        chk_addr1,
    input  logic [ADDR_W-1:0]        chk_addr2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_rdwr;
    logic [ADDR_W-1:0] r_addr3;
    logic [DATA_W-1:0] r_data3;

    logic              w_full;
    logic              w_ld_xfer;
    logic              w_alu_xfer;
    logic [ADDR_W-1:0] w_in_addr;
    logic [DATA_W-1:0] w_in_data;
    logic              w_push;
    logic              w_pop;
    logic              w_haz1;
    logic              w_haz2;

    function automatic logic f_is_dropped(input logic [ADDR_W-1:0] a);
        return (DROP_ZERO != 0) && (a == '0);
    endfunction

    // Full blocks acceptance even when a pop happens on the same edge.
    always_comb begin
        w_full     = (r_count == CNT_W'(DEPTH));
        w_ld_xfer  = ld_valid && !w_full;
        w_alu_xfer = alu_valid && !w_full && !ld_valid;
        w_in_addr  = w_ld_xfer ? ld_addr : alu_addr;
        w_in_data  = w_ld_xfer ? ld_data : alu_data;
        w_push     = (w_ld_xfer || w_alu_xfer) && !f_is_dropped(w_in_addr);
        w_pop      = !wb_stall && (r_count != '0);
    end

    // Scan occupied slots starting at the head; the issue register counts as pending too.
    always_comb begin : hazard_scan
        logic [PTR_W-1:0] w_idx;
        w_idx  = '0;
        w_haz1 = r_rdwr && (r_addr3 == chk_addr1);
        w_haz2 = r_rdwr && (r_addr3 == chk_addr2);
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rptr + PTR_W'(k);
            if (CNT_W'(k) < r_count) begin
                if (r_fifo_addr[w_idx] == chk_addr1) w_haz1 = 1'b1;
                if (r_fifo_addr[w_idx] == chk_addr2) w_haz2 = 1'b1;
            end
        end
        if (f_is_dropped(chk_addr1)) w_haz1 = 1'b0;
        if (f_is_dropped(chk_addr2)) w_haz2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_fifo_addr[r_wptr] <= w_in_addr;
            r_fifo_data[r_wptr] <= w_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rdwr  <= 1'b0;
            r_addr3 <= '0;
            r_data3 <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop) begin
                r_rptr  <= r_rptr + PTR_W'(1);
                r_rdwr  <= 1'b1;
                r_addr3 <= r_fifo_addr[r_rptr];
                r_data3 <= r_fifo_data[r_rptr];
            end else begin
                r_rdwr  <= 1'b0;
            end
        end
    end

    assign ld_ready  = !w_full;
    assign alu_ready = !w_full && !ld_valid;
    assign rdwr      = r_rdwr;
    assign addr3     = r_addr3;
    assign data3     = r_data3;
    assign hazard1   = w_haz1;
    assign hazard2   = w_haz2;
    assign count     = r_count;
    assign empty     = (r_count == '0) && !r_rdwr;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed vector table, hand sequences for fill/wrap
// and reset, and random traffic checked against a queue-based reference model.
module tb_wb_write_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n, alu_valid, ld_valid, wb_stall;
    logic [AW-1:0] alu_addr, ld_addr, chk_addr1, chk_addr2;
    logic [DW-1:0] alu_data, ld_data;
    logic          alu_ready, ld_ready, rdwr, hazard1, hazard2, empty;
    logic [AW-1:0] addr3;
    logic [DW-1:0] data3;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    wb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .DROP_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .wb_stall(wb_stall), .rdwr(rdwr), .addr3(addr3), .data3(data3),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hazard1(hazard1), .hazard2(hazard2),
        .count(count), .empty(empty)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic          m_rdwr;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_d3;
    logic [AW-1:0] issued[$];

    typedef struct {
        logic rst; logic av; logic [AW-1:0] aa; logic [DW-1:0] ad;
        logic lv; logic [AW-1:0] la; logic [DW-1:0] ld; logic st;
        logic [AW-1:0] c1; logic [AW-1:0] c2;
        logic e_ar; logic e_lr; logic e_h1; logic e_h2;
        logic e_rdwr; logic [AW-1:0] e_a3; logic [DW-1:0] e_d3; logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic m_haz(input logic [AW-1:0] c);
        if (c == '0) return 1'b0;
        if (m_rdwr && m_a3 == c) return 1'b1;
        foreach (mq[i]) if (mq[i].a == c) return 1'b1;
        return 1'b0;
    endfunction

    // Reference behaviour at a clock edge, from the pre-edge inputs and queue.
    task automatic model_edge();
        logic   full;
        ent_t   e;
        if (!rst_n) begin
            mq.delete();
            m_rdwr = 1'b0; m_a3 = '0; m_d3 = '0;
        end else begin
            full = (mq.size() == DEPTH);
            if (!wb_stall && mq.size() > 0) begin
                e = mq.pop_front();
                m_rdwr = 1'b1; m_a3 = e.a; m_d3 = e.d;
            end else begin
                m_rdwr = 1'b0;
            end
            if (!full && ld_valid) begin
                if (ld_addr != '0) mq.push_back('{ld_addr, ld_data});
            end else if (!full && alu_valid) begin
                if (alu_addr != '0) mq.push_back('{alu_addr, alu_data});
            end
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input logic st, input logic [AW-1:0] c1, input logic [AW-1:0] c2);
        rst_n = r; alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid = lv; ld_addr = la; ld_data = ld; wb_stall = st;
        chk_addr1 = c1; chk_addr2 = c2;
    endtask

    task automatic pre_edge();
        #1;
        chk("ld_ready", 64'(ld_ready), 64'(mq.size() != DEPTH));
        chk("alu_ready", 64'(alu_ready), 64'(mq.size() != DEPTH && !ld_valid));
        chk("hazard1", 64'(hazard1), 64'(m_haz(chk_addr1)));
        chk("hazard2", 64'(hazard2), 64'(m_haz(chk_addr2)));
        chk("count", 64'(count), 64'(mq.size()));
        chk("empty", 64'(empty), 64'(mq.size() == 0 && !m_rdwr));
    endtask

    task automatic post_edge();
        @(posedge clk);
        model_edge();
        #1;
        chk("rdwr", 64'(rdwr), 64'(m_rdwr));
        chk("addr3", 64'(addr3), 64'(m_a3));
        chk("data3", 64'(data3), 64'(m_d3));
        if (rdwr === 1'b1) issued.push_back(addr3);
    endtask

    task automatic cycle();
        pre_edge();
        post_edge();
    endtask

    task automatic send_alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            drive(1, 1, a, d, 0, 0, 0, 0, 0, 0);
            pre_edge();
            acc = alu_ready;
            post_edge();
        end
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL send_alu_timeout addr %0d: accepted %0b required 1", a, acc);
        end
    endtask

    initial begin
        // rst, av, aa, ad, lv, la, ld, st, c1, c2 | ar, lr, h1, h2 | rdwr, a3, d3, cnt
        tbl[0]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        3'd1};
        tbl[1]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0};
        tbl[2]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 3'd0};
        tbl[3]  = '{1'b1, 1'b1, 5'd4, 32'h22,       1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 3'd1};
        tbl[4]  = '{1'b1, 1'b1, 5'd4, 32'h22,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h11,       3'd1};
        tbl[5]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h22,       3'd0};
        tbl[6]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h22,       3'd0};
        tbl[7]  = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h22,       3'd0};
        tbl[8]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h22,       3'd0};
        tbl[9]  = '{1'b1, 1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h22,       3'd1};
        tbl[10] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h22,       3'd1};
        tbl[11] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77,       3'd0};
        tbl[12] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h77,       3'd0};
        tbl[13] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77,       3'd0};

        // Reset and check the post-reset state.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mq.delete();
        m_rdwr = 1'b0; m_a3 = '0; m_d3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_rdwr", 64'(rdwr), 64'd0);
        chk("reset_addr3", 64'(addr3), 64'd0);
        chk("reset_data3", 64'(data3), 64'd0);
        chk("reset_ld_ready", 64'(ld_ready), 64'd1);
        chk("reset_alu_ready", 64'(alu_ready), 64'd1);
        chk("reset_hazard1", 64'(hazard1), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);

        // Directed vector table: single write, priority, zero drop, hazard.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld,
                  tbl[i].st, tbl[i].c1, tbl[i].c2);
            pre_edge();
            chk($sformatf("tbl%0d_alu_ready", i), 64'(alu_ready), 64'(tbl[i].e_ar));
            chk($sformatf("tbl%0d_ld_ready", i), 64'(ld_ready), 64'(tbl[i].e_lr));
            chk($sformatf("tbl%0d_hazard1", i), 64'(hazard1), 64'(tbl[i].e_h1));
            chk($sformatf("tbl%0d_hazard2", i), 64'(hazard2), 64'(tbl[i].e_h2));
            post_edge();
            chk($sformatf("tbl%0d_rdwr", i), 64'(rdwr), 64'(tbl[i].e_rdwr));
            chk($sformatf("tbl%0d_addr3", i), 64'(addr3), 64'(tbl[i].e_a3));
            chk($sformatf("tbl%0d_data3", i), 64'(data3), 64'(tbl[i].e_d3));
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
        end

        // Fill under stall, then release and drain in order.
        issued.delete();
        for (int a = 1; a <= 4; a++) begin
            drive(1, 1, AW'(a), 32'hA000 + DW'(a), 0, 0, 0, 1, 0, 0);
            cycle();
        end
        drive(1, 1, 5'd5, 32'hA005, 0, 0, 0, 1, 0, 0);
        pre_edge();
        chk("fill_alu_ready", 64'(alu_ready), 64'd0);
        chk("fill_count", 64'(count), 64'd4);
        post_edge();
        send_alu(5'd5, 32'hA005);
        send_alu(5'd6, 32'hA006);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) cycle();
        chk("fill_issued_n", 64'(issued.size()), 64'd6);
        for (int k = 0; k < 6 && k < issued.size(); k++)
            chk($sformatf("fill_order%0d", k), 64'(issued[k]), 64'(k + 1));

        // Eight more entries push the pointers around the ring.
        issued.delete();
        for (int k = 0; k < 8; k++) begin
            send_alu(AW'(9 + k), 32'hB000 + DW'(k));
            if (k % 3 == 2) begin
                drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
                cycle();
            end
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) cycle();
        chk("wrap_issued_n", 64'(issued.size()), 64'd8);
        for (int k = 0; k < 8 && k < issued.size(); k++)
            chk($sformatf("wrap_order%0d", k), 64'(issued[k]), 64'(9 + k));

        // Reset with entries queued discards them.
        for (int a = 1; a <= 3; a++) begin
            drive(1, 1, AW'(20 + a), 32'hC000 + DW'(a), 0, 0, 0, 1, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        chk("rst_mid_count", 64'(count), 64'd0);
        chk("rst_mid_rdwr", 64'(rdwr), 64'd0);
        chk("rst_mid_addr3", 64'(addr3), 64'd0);
        chk("rst_mid_data3", 64'(data3), 64'd0);
        issued.delete();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        chk("rst_mid_no_issue", 64'(issued.size()), 64'd0);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                  DW'($urandom), $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), DW'($urandom),
                  $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
